// File: rtl/synth_pkg.sv
// Shared definitions for the synth output stage.
// Holds the sample and LTC2624 frame widths, the LTC2624 command and address
// constants, the DAC driver FSM state type, and a frame-assembly helper.
package synth_pkg;

  localparam int unsigned SAMPLE_W        = 12;
  localparam int unsigned LTC2624_FRAME_W = 32;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_ALL         = 4'b1111;
  localparam logic [3:0] ADDR_A           = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_STOP,
    ST_GAP
  } dac_state_e;

  // 32-bit LTC2624 word: 8 don't-care bits, command, address, 12-bit data,
  // 4 don't-care bits. Sent MSB first.
  function automatic logic [LTC2624_FRAME_W-1:0] ltc2624_frame(
    input logic [3:0]          cmd,
    input logic [3:0]          addr,
    input logic [SAMPLE_W-1:0] data
  );
    return {8'h00, cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timebase for the DAC SPI driver.
// Emits a one-cycle tick every HALF_PERIOD clocks while enabled; the counter
// is held at zero while disabled so each enable starts a full half-period.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   en_i    count enable
//   tick_o  one-cycle pulse at the end of each half-period
module spi_tick_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// LTC2624 SPI driver: final output stage of the synth.
// Takes 12-bit samples with a ready strobe, keeps one pending sample, and
// sends each as a 32-bit write-and-update command to the DAC, MSB first.
// Frame: START (CS low, SCK low), 32 SCK high/low bit periods, STOP (CS low,
// SCK low), GAP (CS high); each phase step is one half-period.
// Optional build macro: DAC_SIGNED_IN_EN -- when defined, inSample is two's
// complement and is converted to offset binary (MSB inverted) before framing.
// Ports:
//   inClk          system clock
//   inResetN       synchronous active-low reset
//   inSample       12-bit sample
//   inSampleReady  single-cycle strobe, inSample valid this cycle
//   outSpiSck      SPI clock
//   outSpiMosi     SPI data, MSB first
//   outDacCsN      chip select / load, active low
//   outDacClrN     DAC clear, active low (released after reset)
//   outBusy        frame in flight or sample pending
//   outOverrun     pulse when a pending sample is overwritten
module dac_spi_driver
  import synth_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2,
  parameter logic [3:0]  DAC_CMD     = CMD_WRITE_UPDATE,
  parameter logic [3:0]  DAC_ADDR    = ADDR_ALL
) (
  input  logic                inClk,
  input  logic                inResetN,
  input  logic [SAMPLE_W-1:0] inSample,
  input  logic                inSampleReady,
  output logic                outSpiSck,
  output logic                outSpiMosi,
  output logic                outDacCsN,
  output logic                outDacClrN,
  output logic                outBusy,
  output logic                outOverrun
);

  dac_state_e                 state_q, state_d;
  logic [LTC2624_FRAME_W-1:0] sreg_q, sreg_d;
  logic [5:0]                 half_q, half_d;
  logic                       sck_q, sck_d;
  logic                       cs_n_q, cs_n_d;
  logic                       clr_n_q;
  logic [SAMPLE_W-1:0]        slot_q, slot_d;
  logic                       slot_vld_q, slot_vld_d;
  logic                       ovr_q, ovr_d;
  logic                       load;
  logic                       tick;
  logic [SAMPLE_W-1:0]        sample_conv;

`ifdef DAC_SIGNED_IN_EN
  assign sample_conv = {~inSample[SAMPLE_W-1], inSample[SAMPLE_W-2:0]};
`else
  assign sample_conv = inSample;
`endif

  spi_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick (
    .clk_i (inClk),
    .rst_ni(inResetN),
    .en_i  (state_q != ST_IDLE),
    .tick_o(tick)
  );

  // FSM next state. In SHIFT, half_q counts the 64 half-periods of the data
  // phase; SCK starts high on entry and the shift happens on each falling
  // edge. The final low half-period stays in SHIFT before moving to STOP.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    half_d  = half_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (slot_vld_q) begin
          load    = 1'b1;
          sreg_d  = ltc2624_frame(DAC_CMD, DAC_ADDR, slot_q);
          cs_n_d  = 1'b0;
          half_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          sck_d   = 1'b1;
          half_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (half_q == 6'd63) begin
            state_d = ST_STOP;
          end else begin
            half_d = half_q + 6'd1;
            sck_d  = ~sck_q;
            if (sck_q) begin
              sreg_d = {sreg_q[LTC2624_FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending slot: a strobe always wins over the load-clear, so a strobe in
  // the load cycle becomes the next sample without counting as an overrun.
  always_comb begin
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    ovr_d      = 1'b0;
    if (inSampleReady) begin
      slot_d     = sample_conv;
      slot_vld_d = 1'b1;
      ovr_d      = slot_vld_q && !load;
    end else if (load) begin
      slot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge inClk) begin
    if (!inResetN) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      half_q     <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      clr_n_q    <= 1'b0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      half_q     <= half_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      clr_n_q    <= 1'b1;
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign outSpiSck  = sck_q;
  assign outSpiMosi = sreg_q[LTC2624_FRAME_W-1];
  assign outDacCsN  = cs_n_q;
  assign outDacClrN = clr_n_q;
  assign outBusy    = (state_q != ST_IDLE) || slot_vld_q;
  assign outOverrun = ovr_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Self-checking bench for dac_spi_driver: one instance at the default
// half-period and one at HALF_PERIOD=1, sharing stimulus. A bus monitor per
// instance reconstructs the words clocked into the DAC and the CS timing.
module tb_dac_spi_driver;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] sample = '0;
  logic        rdy = 1'b0;

  logic sck0, mosi0, cs0, clr0, busy0, ovr0;
  logic sck1, mosi1, cs1, clr1, busy1, ovr1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  dac_spi_driver dut0 (
    .inClk(clk), .inResetN(rstn), .inSample(sample), .inSampleReady(rdy),
    .outSpiSck(sck0), .outSpiMosi(mosi0), .outDacCsN(cs0), .outDacClrN(clr0),
    .outBusy(busy0), .outOverrun(ovr0)
  );

  dac_spi_driver #(.HALF_PERIOD(1)) dut1 (
    .inClk(clk), .inResetN(rstn), .inSample(sample), .inSampleReady(rdy),
    .outSpiSck(sck1), .outSpiMosi(mosi1), .outDacCsN(cs1), .outDacClrN(clr1),
    .outBusy(busy1), .outOverrun(ovr1)
  );

  // Reference: the word the DAC should receive for a given input sample.
  function automatic logic [31:0] model_frame(input logic [11:0] s);
    logic [11:0] d;
    d = s;
`ifdef DAC_SIGNED_IN_EN
    d = s + 12'h800;  // two's complement -> offset binary
`endif
    return {8'h00, 4'b0011, 4'b1111, d, 4'h0};
  endfunction

  // Bus monitors (sample 1 time unit after each rising clock edge).
  logic [31:0] frames0[$], frames1[$];
  int unsigned bits0[$], bits1[$], low0[$], low1[$];
  logic [31:0] cap0 = '0, cap1 = '0;
  int unsigned rises0 = 0, rises1 = 0, cslow0 = 0, cslow1 = 0;
  int unsigned cshigh0 = 0, lastgap0 = 0, ovrcnt0 = 0, viol0 = 0, viol1 = 0;
  logic psck0 = 1'b0, pcs0 = 1'b1, pmosi0 = 1'b0;
  logic psck1 = 1'b0, pcs1 = 1'b1, pmosi1 = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!cs0) begin
      if (pcs0) begin cap0 = '0; rises0 = 0; cslow0 = 0; lastgap0 = cshigh0; end
      cslow0++;
      if (sck0 && !psck0) begin cap0 = {cap0[30:0], mosi0}; rises0++; end
    end else begin
      if (!pcs0) begin
        frames0.push_back(cap0); bits0.push_back(rises0); low0.push_back(cslow0);
        cshigh0 = 0;
      end
      cshigh0++;
    end
    if (!cs0 && sck0 && mosi0 !== pmosi0) viol0++;
    if (cs0 && pcs0 && sck0 !== psck0) viol0++;
    if (ovr0) ovrcnt0++;
    psck0 = sck0; pcs0 = cs0; pmosi0 = mosi0;
  end

  always @(posedge clk) begin
    #1;
    if (!cs1) begin
      if (pcs1) begin cap1 = '0; rises1 = 0; cslow1 = 0; end
      cslow1++;
      if (sck1 && !psck1) begin cap1 = {cap1[30:0], mosi1}; rises1++; end
    end else if (!pcs1) begin
      frames1.push_back(cap1); bits1.push_back(rises1); low1.push_back(cslow1);
    end
    if (!cs1 && sck1 && mosi1 !== pmosi1) viol1++;
    if (cs1 && pcs1 && sck1 !== psck1) viol1++;
    psck1 = sck1; pcs1 = cs1; pmosi1 = mosi1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [11:0] s);
    sample = s;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic clear_mon();
    frames0.delete(); bits0.delete(); low0.delete();
    frames1.delete(); bits1.delete(); low1.delete();
    ovrcnt0 = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!busy0 && !busy1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sck0, mosi0, cs0, clr0, busy0, ovr0} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_outputs0 got sck/mosi/cs/clr/busy/ovr=%b want 001000",
               {sck0, mosi0, cs0, clr0, busy0, ovr0});
    end
    checks++;
    if ({sck1, mosi1, cs1, clr1, busy1, ovr1} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_outputs1 got %b want 001000", {sck1, mosi1, cs1, clr1, busy1, ovr1});
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (clr0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL clr_release got clr=%b busy=%b want clr=1 busy=0", clr0, busy0);
    end
  endtask

  task automatic test_single();
    int unsigned n, k;
    bit ok;
    clear_mon();
    strobe(12'hABC);
    n = 0;
    while (cs0 !== 1'b0 && n < 8) begin tick(); n++; end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL cs_fall_latency got %0d cycles want 1", n);
    end
    k = 0;
    while (busy0 !== 1'b0 && k < 300) begin tick(); k++; end
    checks++;
    if (k != 134) begin
      failures++;
      $display("FAIL frame_len got %0d cycles want 134", k);
    end
    wait_idle(ok);
    checks++;
    if (frames0.size() != 1 || frames0[0] !== 32'h003FABC0 ||
        model_frame(12'hABC) !== frames0[0]) begin
      failures++;
      $display("FAIL single_frame got n=%0d word=%h want 1 word=%h", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 32'hx, model_frame(12'hABC));
    end
    checks++;
    if (bits0.size() != 1 || bits0[0] != 32 || low0[0] != 132) begin
      failures++;
      $display("FAIL single_timing got rises=%0d cs_low=%0d want 32 and 132",
               bits0.size() > 0 ? bits0[0] : 0, low0.size() > 0 ? low0[0] : 0);
    end
  endtask

  task automatic test_random();
    logic [11:0] s;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      s = 12'($urandom_range(0, 4095));
      repeat ($urandom_range(0, 5)) tick();
      strobe(s);
      wait_idle(ok);
      checks++;
      if (!ok || frames0.size() != 1 || frames0[0] !== model_frame(s) || bits0[0] != 32) begin
        failures++;
        $display("FAIL random_frame sample=%h got n=%0d word=%h want word=%h", s,
                 frames0.size(), frames0.size() > 0 ? frames0[0] : 32'hx, model_frame(s));
      end
    end
  endtask

  task automatic test_overrun();
    logic [11:0] first;
    bit ok;
    clear_mon();
    first = 12'($urandom_range(0, 4095));
    strobe(first);
    repeat (20) tick();
    strobe(12'h123);
    repeat (10) tick();
    strobe(12'h456);
    wait_idle(ok);
    checks++;
    if (!ok || frames0.size() != 2 || frames0[0] !== model_frame(first) ||
        frames0[1] !== model_frame(12'h456)) begin
      failures++;
      $display("FAIL overrun_frames got n=%0d w0=%h w1=%h want %h %h", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 32'hx, frames0.size() > 1 ? frames0[1] : 32'hx,
               model_frame(first), model_frame(12'h456));
    end
    checks++;
    if (ovrcnt0 != 1) begin
      failures++;
      $display("FAIL overrun_pulses got %0d want 1", ovrcnt0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    sample = 12'h001;
    rdy = 1'b1;
    tick();
    sample = 12'h7FF;  // lands in the load cycle of 12'h001
    tick();
    rdy = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || frames0.size() != 2 || frames0[0] !== model_frame(12'h001) ||
        frames0[1] !== model_frame(12'h7FF)) begin
      failures++;
      $display("FAIL b2b_frames got n=%0d w0=%h w1=%h want %h %h", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 32'hx, frames0.size() > 1 ? frames0[1] : 32'hx,
               model_frame(12'h001), model_frame(12'h7FF));
    end
    checks++;
    if (ovrcnt0 != 0) begin
      failures++;
      $display("FAIL b2b_overrun got %0d pulses want 0", ovrcnt0);
    end
    // CS high: two GAP cycles plus the IDLE cycle that loads the next word.
    checks++;
    if (lastgap0 != 3) begin
      failures++;
      $display("FAIL b2b_gap got %0d cycles CS high want 3", lastgap0);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned n;
    bit ok;
    clear_mon();
    strobe(12'h5A5);
    n = 0;
    while (!(cs0 === 1'b0 && rises0 == 10) && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL midframe_reach got timeout want 10 SCK rises");
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (cs0 !== 1'b1 || sck0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got cs=%b sck=%b busy=%b want 1 0 0", cs0, sck0, busy0);
    end
    rstn = 1'b1;
    tick();
    clear_mon();
    strobe(12'hFFF);
    wait_idle(ok);
    checks++;
    if (!ok || frames0.size() != 1 || frames0[0] !== model_frame(12'hFFF) || bits0[0] != 32) begin
      failures++;
      $display("FAIL post_reset_frame got n=%0d word=%h want %h", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 32'hx, model_frame(12'hFFF));
    end
  endtask

  task automatic test_half_period_1();
    int unsigned n, k;
    bit ok;
    clear_mon();
    strobe(12'h000);
    n = 0;
    while (cs1 !== 1'b0 && n < 8) begin tick(); n++; end
    k = 0;
    while (busy1 !== 1'b0 && k < 200) begin tick(); k++; end
    checks++;
    if (n != 1 || k != 67) begin
      failures++;
      $display("FAIL hp1_frame_len got latency=%0d len=%0d want 1 and 67", n, k);
    end
    wait_idle(ok);
    checks++;
    if (frames1.size() != 1 || frames1[0] !== model_frame(12'h000) ||
        bits1[0] != 32 || low1[0] != 66) begin
      failures++;
      $display("FAIL hp1_frame got n=%0d word=%h rises=%0d cs_low=%0d want %h 32 66",
               frames1.size(), frames1.size() > 0 ? frames1[0] : 32'hx,
               bits1.size() > 0 ? bits1[0] : 0, low1.size() > 0 ? low1[0] : 0,
               model_frame(12'h000));
    end
  endtask

  task automatic test_signed();
    logic [11:0] want_a, want_b;
    bit ok;
`ifdef DAC_SIGNED_IN_EN
    want_a = 12'h000; want_b = 12'hFFF;
`else
    want_a = 12'h800; want_b = 12'h7FF;
`endif
    clear_mon();
    strobe(12'h800);
    wait_idle(ok);
    strobe(12'h7FF);
    wait_idle(ok);
    checks++;
    if (frames0.size() != 2 || frames0[0][15:4] !== want_a || frames0[1][15:4] !== want_b) begin
      failures++;
      $display("FAIL data_field got n=%0d d0=%h d1=%h want %h %h", frames0.size(),
               frames0.size() > 0 ? frames0[0][15:4] : 12'hx,
               frames0.size() > 1 ? frames0[1][15:4] : 12'hx, want_a, want_b);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol0 != 0 || viol1 != 0) begin
      failures++;
      $display("FAIL bus_protocol got violations=%0d/%0d want 0/0", viol0, viol1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_half_period_1();
    test_signed();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
